// File: rtl/dm_resp.sv
// dm_resp: single-outstanding data memory responder.
// A request is accepted in IDLE, held in WAIT for LATENCY edges and then
// answered in RESP, where the response is held until the initiator takes it.
// On the edge that enters RESP the store (if any) is committed and the
// addressed word (post-write for stores) is captured into resp_rdata.
// Illegal requests (out of range, bad byte-enable pattern or misalignment)
// return resp_err=1 with rdata=0 and leave the storage untouched.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset; clears FSM, outputs and storage
//   req_valid   request present
//   req_ready   block can accept a request (IDLE only)
//   req_we      1=store, 0=load
//   req_addr    byte address
//   req_wdata   store data, lanes already aligned
//   req_be      byte enables, bit i selects bits [8i+7:8i]
//   resp_valid  response present (RESP only)
//   resp_ready  initiator takes the response
//   resp_rdata  full addressed word
//   resp_err    request rejected, no side effect
module dm_resp #(
   parameter int DEPTH   = 3072,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Reject parameter values the datapath cannot represent.
   generate
      if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
         $error("dm_resp: LATENCY must be in 1..15");
      end
      if (DEPTH < 1 || DEPTH > (1 << 30)) begin : g_bad_depth
         $error("dm_resp: DEPTH must be in 1..2^30");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_r;
   logic [3:0]  cnt_r;
   logic        we_r;
   logic [31:0] addr_r;
   logic [31:0] wdata_r;
   logic [3:0]  be_r;
   logic        req_ready_r;
   logic        resp_valid_r;
   logic [31:0] resp_rdata_r;
   logic        resp_err_r;

   logic [31:0] mem_r [0:DEPTH-1];

   logic          in_range_s;
   logic          err_s;
   logic [AW-1:0] idx_s;
   logic [31:0]   rd_word_s;
   logic [31:0]   wr_word_s;
   logic          fire_s;
   logic          wr_en_s;

   // Replace the enabled byte lanes of old_w with those of new_w.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
      logic [31:0] m;
      m = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            m[8*i +: 8] = new_w[8*i +: 8];
         end else begin
            m[8*i +: 8] = old_w[8*i +: 8];
         end
      end
      return m;
   endfunction

   // Legal byte-enable patterns and their alignment constraints.
   function automatic logic be_legal(input logic [3:0] be, input logic [1:0] lo);
      logic ok;
      case (be)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
         4'b0011, 4'b1100:                   ok = ~lo[0];
         4'b1111:                            ok = (lo == 2'b00);
         default:                            ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Decode the latched request: range, legality, read and merged words.
   always_comb begin
      in_range_s = ({2'b00, addr_r[31:2]} < 32'(DEPTH));
      err_s      = ~in_range_s | ~be_legal(be_r, addr_r[1:0]);
      idx_s      = addr_r[AW+1:2];
      if (in_range_s) begin
         rd_word_s = mem_r[idx_s];
      end else begin
         rd_word_s = 32'h0000_0000;
      end
      if (we_r) begin
         wr_word_s = merge_bytes(rd_word_s, wdata_r, be_r);
      end else begin
         wr_word_s = rd_word_s;
      end
      fire_s  = (state_r == WAIT) && (cnt_r == 4'd0);
      wr_en_s = fire_s & ~err_s & we_r;
   end

   // Request/response FSM with registered handshake outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r      <= IDLE;
         cnt_r        <= 4'd0;
         we_r         <= 1'b0;
         addr_r       <= 32'h0000_0000;
         wdata_r      <= 32'h0000_0000;
         be_r         <= 4'b0000;
         req_ready_r  <= 1'b1;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= 32'h0000_0000;
         resp_err_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (req_valid) begin
                  we_r        <= req_we;
                  addr_r      <= req_addr;
                  wdata_r     <= req_wdata;
                  be_r        <= req_be;
                  cnt_r       <= 4'(LATENCY - 1);
                  req_ready_r <= 1'b0;
                  state_r     <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_r == 4'd0) begin
                  resp_valid_r <= 1'b1;
                  resp_err_r   <= err_s;
                  resp_rdata_r <= err_s ? 32'h0000_0000 : wr_word_s;
                  state_r      <= RESP;
               end else begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            RESP: begin
               // Handshake edge returns to IDLE; acceptance starts one edge later.
               if (resp_ready) begin
                  resp_valid_r <= 1'b0;
                  resp_err_r   <= 1'b0;
                  req_ready_r  <= 1'b1;
                  state_r      <= IDLE;
               end
            end
            default: begin
               state_r      <= IDLE;
               cnt_r        <= 4'd0;
               req_ready_r  <= 1'b1;
               resp_valid_r <= 1'b0;
               resp_err_r   <= 1'b0;
            end
         endcase
      end
   end

   // Storage array; cleared by reset, written on the edge entering RESP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 32'h0000_0000;
         end
      end else if (wr_en_s) begin
         mem_r[idx_s] <= wr_word_s;
      end
   end

   assign req_ready  = req_ready_r;
   assign resp_valid = resp_valid_r;
   assign resp_rdata = resp_rdata_r;
   assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_dm_resp.sv
// Directed bench for dm_resp: expected responses are queued when a request is
// driven and popped when the response appears. A second LATENCY=1 instance
// checks back-to-back request spacing.
module tb_dm_resp;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_we;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_be;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;

   logic        req_valid1, req_ready1, req_we1;
   logic [31:0] req_addr1, req_wdata1;
   logic [3:0]  req_be1;
   logic        resp_valid1, resp_ready1, resp_err1;
   logic [31:0] resp_rdata1;

   int checks = 0;
   int errors = 0;
   logic [32:0] exp_q [$];

   dm_resp #(.DEPTH(3072), .LATENCY(LAT)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   dm_resp #(.DEPTH(16), .LATENCY(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
      .req_addr(req_addr1), .req_wdata(req_wdata1), .req_be(req_be1),
      .resp_valid(resp_valid1), .resp_ready(resp_ready1),
      .resp_rdata(resp_rdata1), .resp_err(resp_err1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // One full transaction; hold>0 stalls resp_ready and pulses a stray request.
   task automatic send(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rd, input logic exp_err, input int hold);
      int n;
      logic [32:0] e;
      logic [31:0] rd0;
      logic er0;
      exp_q.push_back({exp_err, exp_rd});
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ":ready"}, 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
      n = 0;
      while (resp_valid !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, ":latency"}, 32'(n), 32'(LAT));
      e = exp_q.pop_front();
      chk({tag, ":rdata"}, resp_rdata, e[31:0]);
      chk({tag, ":err"}, 32'(resp_err), 32'(e[32]));
      rd0 = resp_rdata;
      er0 = resp_err;
      for (int c = 0; c < hold; c++) begin
         @(negedge clk);
         if (c == 1) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40;
            req_wdata = 32'hDEAD_BEEF; req_be = 4'hF;
         end else begin
            req_valid = 1'b0;
         end
         @(posedge clk); #1;
         chk({tag, ":hold_valid"}, 32'(resp_valid), 32'd1);
         chk({tag, ":hold_rdata"}, resp_rdata, rd0);
         chk({tag, ":hold_err"}, 32'(resp_err), 32'(er0));
         chk({tag, ":hold_ready"}, 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      req_valid = 1'b0; resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk({tag, ":rel_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, ":rel_err"}, 32'(resp_err), 32'd0);
      chk({tag, ":rel_ready"}, 32'(req_ready), 32'd1);
   endtask

   initial begin
      int acc [$];
      reset = 1'b0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_be = 4'h0;
      resp_ready = 1'b0;
      req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = 32'h0; req_wdata1 = 32'h0; req_be1 = 4'h0;
      resp_ready1 = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 32'(resp_valid), 32'd0);
      chk("rst_rdata", resp_rdata, 32'h0);
      chk("rst_err", 32'(resp_err), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready", 32'(req_ready), 32'd1);

      // Basic load / store / partial store
      send("ld0",     1'b0, 32'h0,  32'h0,         4'hF, 32'h0000_0000, 1'b0, 0);
      send("st10",    1'b1, 32'h10, 32'h1234_5678, 4'hF, 32'h1234_5678, 1'b0, 0);
      send("ld10",    1'b0, 32'h10, 32'h0,         4'hF, 32'h1234_5678, 1'b0, 0);
      send("st11b",   1'b1, 32'h11, 32'h0000_AB00, 4'h2, 32'h1234_AB78, 1'b0, 0);

      // Range boundary and illegal patterns
      send("st2ffc",  1'b1, 32'h2FFC, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D, 1'b0, 0);
      send("st3002",  1'b1, 32'h3002, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1, 0);
      send("ld3000",  1'b0, 32'h3000, 32'h0,         4'hF, 32'h0000_0000, 1'b1, 0);
      send("ld2ffc",  1'b0, 32'h2FFC, 32'h0,         4'hF, 32'hCAFE_F00D, 1'b0, 0);
      send("st24hi",  1'b1, 32'h26, 32'hBEEF_0000, 4'hC, 32'hBEEF_0000, 1'b0, 0);
      send("st25odd", 1'b1, 32'h25, 32'h0000_1111, 4'h3, 32'h0000_0000, 1'b1, 0);
      send("st24bad", 1'b1, 32'h24, 32'h1111_1111, 4'h5, 32'h0000_0000, 1'b1, 0);
      send("st24be0", 1'b1, 32'h24, 32'h1111_1111, 4'h0, 32'h0000_0000, 1'b1, 0);
      send("ld24",    1'b0, 32'h24, 32'h0,         4'hF, 32'hBEEF_0000, 1'b0, 0);

      // Stalled response with a stray request pulse
      send("stall",   1'b0, 32'h10, 32'h0,         4'hF, 32'h1234_AB78, 1'b0, 5);
      send("ld40",    1'b0, 32'h40, 32'h0,         4'hF, 32'h0000_0000, 1'b0, 0);

      // Reset during WAIT discards the store
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rw_inwait", 32'(req_ready), 32'd0);
      #2 reset = 1'b0;
      #1;
      chk("rw_clear_valid", 32'(resp_valid), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rw_ready", 32'(req_ready), 32'd1);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         chk("rw_noresp", 32'(resp_valid), 32'd0);
      end
      send("ld20",    1'b0, 32'h20, 32'h0,         4'hF, 32'h0000_0000, 1'b0, 0);
      send("ld10clr", 1'b0, 32'h10, 32'h0,         4'hF, 32'h0000_0000, 1'b0, 0);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      // LATENCY=1 back-to-back spacing
      @(negedge clk);
      req_valid1 = 1'b1; req_we1 = 1'b0; req_addr1 = 32'h4; req_be1 = 4'hF; resp_ready1 = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (req_valid1 && req_ready1) acc.push_back(c);
         @(negedge clk);
      end
      req_valid1 = 1'b0;
      chk("l1_accepts", 32'(acc.size() >= 4), 32'd1);
      if (acc.size() >= 4) begin
         for (int i = 1; i < 4; i++) begin
            chk("l1_spacing", 32'(acc[i] - acc[i-1]), 32'd3);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dm_resp.md
DM_RESP -- requirements
Module: dm_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 3072, meaning the number of 32-bit storage words (12 KiB).
REQ-002 SHALL have parameter LATENCY, default 2, meaning clock edges from request acceptance to response valid; legal range is 1..15.
REQ-003 SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; reset=0 resets the block.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port req_we  input  1  1=store, 0=load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, byte lanes already aligned.
REQ-010 SHALL have port req_be  input  4  byte enables, bit i selects bits [8i+7:8i].
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  initiator takes response.
REQ-013 SHALL have port resp_rdata  output  32  full addressed word.
REQ-014 SHALL have port resp_err  output  1  request rejected, no side effect.

Function
REQ-015 SHALL implement states IDLE, WAIT, RESP; req_ready=1 only in IDLE; resp_valid=1 only in RESP.
REQ-016 SHALL accept a request on a rising edge where state=IDLE and req_valid=1, latch we/addr/wdata/be, load the latency counter with LATENCY-1, and enter WAIT.
REQ-017 SHALL, in WAIT, decrement the counter each edge while nonzero, and on the edge where the counter is 0 enter RESP; resp_valid therefore rises exactly LATENCY edges after the accept edge.
REQ-018 SHALL ignore req_* inputs outside IDLE; only one request is outstanding at a time.
REQ-019 SHALL compute word index = addr[31:2]; the request is in range iff the index < DEPTH.
REQ-020 SHALL flag an error when any of these holds: the request is out of range; req_be is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111; be=0011/1100 with addr[0]=1; be=1111 with addr[1:0]!=0.
REQ-021 SHALL, on the edge entering RESP with no error, write the enabled bytes of the latched wdata when the request is a store, and capture the word into resp_rdata; a store returns the post-write word.
REQ-022 SHALL, on the edge entering RESP with an error, perform no write, set resp_rdata=0, and set resp_err=1.
REQ-023 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready=1; on that edge it SHALL return to IDLE with resp_err=0.
REQ-024 SHALL not accept a new request on the response-handshake edge; the minimum request-to-request interval is LATENCY+2 edges.
REQ-025 SHALL leave bytes not enabled unchanged on a store.

Reset
REQ-026 SHALL, while reset=0 and independent of clk, force state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, and all storage words to 0.
REQ-027 SHALL, when reset is asserted mid-transaction (WAIT or RESP), discard the transaction with no write; req_ready SHALL be 1 from the first edge after reset is released.
REQ-028 SHALL treat an out-of-range LATENCY or DEPTH as an elaboration error.

Verification
REQ-029 SHALL be checked with the following scenario: after reset, load of addr 0x0 -> resp_valid at accept+2 edges, rdata=0x00000000, err=0.
REQ-030 SHALL be checked with the following scenario: store 0x12345678 be=1111 to 0x10, then load 0x10 -> rdata=0x12345678; then store 0x0000AB00 be=0010 to 0x11 -> returned word 0x1234AB78.
REQ-031 SHALL be checked with the following scenario: store be=1111 to 0x3002 -> err=1, rdata=0; a following load of 0x3000 is out of range (index 3072) -> err=1, and the contents at 0x2FFC are unchanged.
REQ-032 SHALL be checked with the following scenario: resp_ready held 0 for 5 cycles -> resp_valid, rdata and err stay constant, req_ready=0, and a req_valid pulse meanwhile is ignored.
REQ-033 SHALL be checked with the following scenario: store 0xFFFFFFFF to 0x20 with reset pulsed low during WAIT -> no response; a later load of 0x20 -> 0x00000000.
REQ-034 SHALL be checked with the following scenario: LATENCY=1 build, back-to-back requests with req_valid held high -> accepts spaced exactly 3 edges apart.
